mm_array_sequencer: RTL and testbench

- Cycle-level controller for the SIZE x SIZE systolic matrix-multiply array.
- On each job it does four things in order: clears the PE accumulators, streams N operand-slice indices into the operand fetch path, waits out the systolic skew, then sequences N result-row writebacks.
- Sits between the host/job interface and the operand buffers and array, replacing ad-hoc index counters with a single FSM that has handshakes.

---
 rtl/mm_array_sequencer.sv | 154 +++++++++++++++
 tb/tb_mm_array_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_array_sequencer.sv
// rtl/mm_array_sequencer.sv - job sequencer for the SIZE x SIZE systolic matrix-multiply array
// Optional feature macro: MM_SEQ_PERF_CNT_EN (adds the 16-bit stall_cnt output)
module mm_array_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 6,
  parameter int IDX_W      = 4,
  parameter int DRAIN_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             pe_clear,
  output logic             feed_valid,
  output logic [IDX_W-1:0] feed_idx,
  input  logic             feed_ready,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_row,
  input  logic             wb_ready
`ifdef MM_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // A misconfigured instance (index or drain counter too narrow) refuses every job
  // rather than silently wrapping its counters.
  localparam logic CFG_OK = (DATA_WIDTH > 0) &&
                            ((1 << IDX_W) > SIZE) &&
                            ((1 << DRAIN_W) > (2 * SIZE - 2));
  localparam logic [IDX_W-1:0] SIZE_N = IDX_W'(SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   n_lat;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               n_legal;
  logic [IDX_W-1:0]   n_last;
  logic [DRAIN_W-1:0] drain_load;

  assign n_legal    = CFG_OK && (n != '0) && (n <= SIZE_N);
  assign n_last     = n_lat - IDX_W'(1);
  // Systolic skew: the last partial product leaves the array 2N-2 cycles after the last feed.
  assign drain_load = (DRAIN_W'(n_lat) << 1) - DRAIN_W'(2);

  // Job FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      n_lat      <= '0;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pe_clear   <= 1'b0;
      feed_valid <= 1'b0;
      feed_idx   <= '0;
      wb_valid   <= 1'b0;
      wb_row     <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      pe_clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (n_legal) begin
              n_lat    <= n;
              busy     <= 1'b1;
              pe_clear <= 1'b1;
              state    <= ST_CLEAR;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          feed_valid <= 1'b1;
          feed_idx   <= '0;
          state      <= ST_FEED;
        end
        ST_FEED: begin
          if (feed_ready) begin
            if (feed_idx == n_last) begin
              feed_valid <= 1'b0;
              if (n_lat == IDX_W'(1)) begin
                wb_valid <= 1'b1;
                wb_row   <= '0;
                state    <= ST_WRITE;
              end else begin
                drain_cnt <= drain_load;
                state     <= ST_DRAIN;
              end
            end else begin
              feed_idx <= feed_idx + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - DRAIN_W'(1);
          if (drain_cnt == DRAIN_W'(1)) begin
            wb_valid <= 1'b1;
            wb_row   <= '0;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wb_ready) begin
            if (wb_row == n_last) begin
              wb_valid <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              wb_row <= wb_row + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MM_SEQ_PERF_CNT_EN
  // Saturating count of backpressured cycles, restarted when a job is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE) && start && n_legal) begin
      stall_cnt <= '0;
    end else if (((feed_valid && !feed_ready) || (wb_valid && !wb_ready)) &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_array_sequencer.sv
// tb/tb_mm_array_sequencer.sv - self-checking bench for mm_array_sequencer
module tb_mm_array_sequencer;
  localparam int SIZE  = 6;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] n = '0;
  logic             feed_ready = 1'b0;
  logic             wb_ready = 1'b0;
  logic             busy, done, err, pe_clear, feed_valid, wb_valid;
  logic [IDX_W-1:0] feed_idx, wb_row;
`ifdef MM_SEQ_PERF_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // results of the last job, gathered by run_job
  int r_lat, r_clear, r_drain, r_busy_low, r_stalls, r_hold_bad, r_done_cnt, r_err;
  bit r_timeout, r_post_busy;
  int r_feeds[$];
  int r_wbs[$];

  always #5 clk = ~clk;

  mm_array_sequencer #(
    .DATA_WIDTH(32), .SIZE(SIZE), .IDX_W(IDX_W), .DRAIN_W(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .busy(busy), .done(done), .err(err), .pe_clear(pe_clear),
    .feed_valid(feed_valid), .feed_idx(feed_idx), .feed_ready(feed_ready),
    .wb_valid(wb_valid), .wb_row(wb_row), .wb_ready(wb_ready)
`ifdef MM_SEQ_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // reference: an accepted index stream must be exactly 0,1,...,len-1
  function automatic bit is_ramp(input int q[$], input int len);
    if (q.size() != len) return 1'b0;
    for (int i = 0; i < len; i++) if (q[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  // Runs one job from IDLE; called #1 after a rising edge. Ready inputs come from
  // randomness or a stall pattern (stall len cycles when index == at).
  task automatic run_job(input int nj, input bit rnd, input int fs_at, input int fs_len,
                         input int ws_at, input int ws_len, input bit inject);
    int fs_used, ws_used;
    bit pfv, pfr, pwv, pwr, injected, seen_done;
    logic [IDX_W-1:0] pfi, pwi;
    r_lat = -1; r_clear = 0; r_drain = 0; r_busy_low = 0; r_stalls = 0; r_hold_bad = 0;
    r_done_cnt = 0; r_err = 0; r_timeout = 1'b1; r_post_busy = 1'b1;
    r_feeds.delete(); r_wbs.delete();
    fs_used = 0; ws_used = 0; injected = 1'b0; seen_done = 1'b0;
    pfv = 1'b0; pfr = 1'b0; pwv = 1'b0; pwr = 1'b0; pfi = '0; pwi = '0;
    start = 1'b1; n = IDX_W'(nj); feed_ready = 1'b1; wb_ready = 1'b1;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk); #1;
      if (pfv && pfr) r_feeds.push_back(int'(pfi));
      if (pfv && !pfr) begin
        r_stalls++;
        if (!feed_valid || feed_idx !== pfi) r_hold_bad++;
      end
      if (pwv && pwr) r_wbs.push_back(int'(pwi));
      if (pwv && !pwr) begin
        r_stalls++;
        if (!wb_valid || wb_row !== pwi) r_hold_bad++;
      end
      if (pe_clear) r_clear++;
      if (err) r_err++;
      if (done) r_done_cnt++;
      if (seen_done) begin
        r_timeout = 1'b0;
        r_post_busy = busy;
        break;
      end
      if (!busy) r_busy_low++;
      if (busy && !pe_clear && !feed_valid && !wb_valid && !done) r_drain++;
      if (done) begin seen_done = 1'b1; r_lat = e; end
      start = 1'b0;
      n = IDX_W'($urandom);
      if (inject && !injected && feed_valid && feed_idx == IDX_W'(1)) begin
        start = 1'b1; n = IDX_W'(2); injected = 1'b1;
      end
      feed_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (feed_valid && int'(feed_idx) == fs_at && fs_used < fs_len) begin
        feed_ready = 1'b0; fs_used++;
      end
      wb_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (wb_valid && int'(wb_row) == ws_at && ws_used < ws_len) begin
        wb_ready = 1'b0; ws_used++;
      end
      pfv = feed_valid; pfi = feed_idx; pfr = feed_ready;
      pwv = wb_valid;   pwi = wb_row;   pwr = wb_ready;
    end
    start = 1'b0;
    feed_ready = 1'b1;
    wb_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({busy, done, err, pe_clear, feed_valid, wb_valid, feed_idx, wb_row} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b clr=%b fv=%b wv=%b fi=%0d wr=%0d, want all 0",
               busy, done, err, pe_clear, feed_valid, wb_valid, feed_idx, wb_row);
    end
`ifdef MM_SEQ_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    run_job(6, 1'b0, -1, 0, -1, 0, 1'b0);
    checks++;
    if (r_timeout) begin errors++; $display("FAIL nominal_timeout: no done within budget"); end
    checks++;
    if (r_lat != 24) begin errors++; $display("FAIL nominal_latency: got %0d want 24", r_lat); end
    checks++;
    if (r_clear != 1) begin errors++; $display("FAIL nominal_pe_clear: got %0d cycles want 1", r_clear); end
    checks++;
    if (!is_ramp(r_feeds, 6)) begin errors++; $display("FAIL nominal_feeds: got %0d feeds want 0..5", r_feeds.size()); end
    checks++;
    if (r_drain != 10) begin errors++; $display("FAIL nominal_drain: got %0d want 10", r_drain); end
    checks++;
    if (!is_ramp(r_wbs, 6)) begin errors++; $display("FAIL nominal_wbs: got %0d rows want 0..5", r_wbs.size()); end
    checks++;
    if (r_busy_low != 0 || r_post_busy) begin
      errors++; $display("FAIL nominal_busy: low_cycles=%0d post_busy=%b want 0/0", r_busy_low, r_post_busy);
    end
    checks++;
    if (r_done_cnt != 1) begin errors++; $display("FAIL nominal_done_pulse: got %0d want 1", r_done_cnt); end
  endtask

  task automatic test_minimum();
    run_job(1, 1'b0, -1, 0, -1, 0, 1'b0);
    checks++;
    if (r_lat != 4) begin errors++; $display("FAIL min_latency: got %0d want 4", r_lat); end
    checks++;
    if (r_drain != 0) begin errors++; $display("FAIL min_drain: got %0d want 0", r_drain); end
    checks++;
    if (!is_ramp(r_feeds, 1) || !is_ramp(r_wbs, 1) || r_clear != 1) begin
      errors++; $display("FAIL min_sequence: feeds=%0d wbs=%0d clr=%0d want 1/1/1", r_feeds.size(), r_wbs.size(), r_clear);
    end
  endtask

  task automatic test_illegal();
    int bad_n[3];
    bad_n[0] = 0; bad_n[1] = SIZE + 1; bad_n[2] = $urandom_range(SIZE + 1, 15);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; n = IDX_W'(bad_n[i]);
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || pe_clear !== 1'b0) begin
        errors++; $display("FAIL illegal_err n=%0d: err=%b busy=%b clr=%b want 1/0/0", bad_n[i], err, busy, pe_clear);
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || feed_valid !== 1'b0 || wb_valid !== 1'b0 || pe_clear !== 1'b0) begin
        errors++; $display("FAIL illegal_after n=%0d: err=%b busy=%b fv=%b wv=%b clr=%b want all 0",
                           bad_n[i], err, busy, feed_valid, wb_valid, pe_clear);
      end
    end
  endtask

  task automatic test_backpressure();
    run_job(3, 1'b0, 1, 2, 2, 3, 1'b0);
    checks++;
    if (r_stalls != 5) begin errors++; $display("FAIL bp_stalls: got %0d want 5", r_stalls); end
    checks++;
    if (r_lat != 12 + 5) begin errors++; $display("FAIL bp_latency: got %0d want 17", r_lat); end
    checks++;
    if (r_hold_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls want 0", r_hold_bad); end
    checks++;
    if (!is_ramp(r_feeds, 3) || !is_ramp(r_wbs, 3)) begin
      errors++; $display("FAIL bp_sequence: feeds=%0d wbs=%0d want 3/3", r_feeds.size(), r_wbs.size());
    end
`ifdef MM_SEQ_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); end
`endif
  endtask

  task automatic test_start_busy();
    run_job(4, 1'b0, -1, 0, -1, 0, 1'b1);
    checks++;
    if (r_lat != 16) begin errors++; $display("FAIL busy_start_latency: got %0d want 16", r_lat); end
    checks++;
    if (!is_ramp(r_feeds, 4) || !is_ramp(r_wbs, 4) || r_err != 0) begin
      errors++; $display("FAIL busy_start_sequence: feeds=%0d wbs=%0d err=%0d want 4/4/0",
                         r_feeds.size(), r_wbs.size(), r_err);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int nj;
      nj = $urandom_range(1, SIZE);
      run_job(nj, 1'b1, -1, 0, -1, 0, 1'b0);
      checks++;
      if (r_timeout || r_lat != 4 * nj + r_stalls) begin
        errors++; $display("FAIL rand_latency job%0d n=%0d: got %0d want %0d", j, nj, r_lat, 4 * nj + r_stalls);
      end
      checks++;
      if (!is_ramp(r_feeds, nj) || !is_ramp(r_wbs, nj)) begin
        errors++; $display("FAIL rand_sequence job%0d n=%0d: feeds=%0d wbs=%0d", j, nj, r_feeds.size(), r_wbs.size());
      end
      checks++;
      if (r_hold_bad != 0 || r_drain != 2 * nj - 2 || r_busy_low != 0 || r_done_cnt != 1) begin
        errors++; $display("FAIL rand_rules job%0d n=%0d: hold_bad=%0d drain=%0d busy_low=%0d done=%0d want 0/%0d/0/1",
                           j, nj, r_hold_bad, r_drain, r_busy_low, r_done_cnt, 2 * nj - 2);
      end
`ifdef MM_SEQ_PERF_CNT_EN
      checks++;
      if (int'(stall_cnt) != r_stalls) begin
        errors++; $display("FAIL rand_stall_cnt job%0d: got %0d want %0d", j, stall_cnt, r_stalls);
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    int dones;
    found = 1'b0;
    dones = 0;
    start = 1'b1; n = IDX_W'(5); feed_ready = 1'b1; wb_ready = 1'b1;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy && !pe_clear && !feed_valid && !wb_valid && !done) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_reach_drain: drain phase not seen"); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, pe_clear, feed_valid, wb_valid, feed_idx, wb_row} !== '0) begin
      errors++; $display("FAIL midrst_async: busy=%b done=%b fv=%b wv=%b fi=%0d wr=%0d want all 0",
                         busy, done, feed_valid, wb_valid, feed_idx, wb_row);
    end
`ifdef MM_SEQ_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (e == 2) rst = 1'b1;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses want 0", dones); end
    run_job(2, 1'b0, -1, 0, -1, 0, 1'b0);
    checks++;
    if (r_lat != 8 || !is_ramp(r_feeds, 2) || !is_ramp(r_wbs, 2)) begin
      errors++; $display("FAIL midrst_next_job: lat=%0d feeds=%0d wbs=%0d want 8/2/2", r_lat, r_feeds.size(), r_wbs.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_minimum();
    test_illegal();
    test_backpressure();
    test_start_busy();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
